// File: rtl/branch_tag_ctrl.sv
// branch_tag_ctrl: circular branch-tag allocator with free-oldest, range kill and sticky error flag.
module branch_tag_ctrl #(
    parameter  int WIDTH_BRM = 4,
    localparam int N         = 2 ** WIDTH_BRM
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_alloc,
    input  logic                 i_free,
    input  logic [N-1:0]         i_brkill,
    output logic                 o_ready,
    output logic                 o_ack,
    output logic [WIDTH_BRM-1:0] o_alloc_tag,
    output logic [WIDTH_BRM-1:0] o_brmask,
    output logic [N-1:0]         o_live,
    output logic [WIDTH_BRM-1:0] o_count,
    output logic                 o_err
);
    localparam logic [WIDTH_BRM-1:0] C_MAX = WIDTH_BRM'(N - 1);

    logic [WIDTH_BRM-1:0] r_tail, r_head, r_count;
    logic [N-1:0]         r_live;
    logic                 r_err;

    logic                 w_kill, w_kill_bad, w_kill_ok, w_free_ok, w_err_n;
    logic [WIDTH_BRM-1:0] w_kill_tail, w_tail_n, w_head_n, w_count_n;
    logic [WIDTH_BRM:0]   w_kill_pop, w_cnt_up, w_cnt_dn;
    logic [N-1:0]         w_live_n;

    assign w_kill      = |i_brkill;
    assign w_kill_bad  = (&i_brkill) | (i_free & i_brkill[r_head]);
    assign w_kill_ok   = w_kill & ~w_kill_bad;
    assign w_free_ok   = i_free & (r_count != '0);

    assign o_ready     = (r_count != C_MAX);
    assign o_ack       = i_alloc & o_ready & ~w_kill;
    assign o_alloc_tag = r_tail + WIDTH_BRM'(1);
    assign o_brmask    = r_tail;
    assign o_live      = r_live;
    assign o_count     = r_count;
    assign o_err       = r_err;

    // New tail is the tag just below the killed run; scanning downward leaves the lowest match.
    always_comb begin
        w_kill_tail = '0;
        w_kill_pop  = '0;
        for (int i = N - 1; i >= 0; i--) begin
            w_kill_pop = w_kill_pop + {{WIDTH_BRM{1'b0}}, i_brkill[i]};
            if (!i_brkill[i] && i_brkill[(i + 1) % N])
                w_kill_tail = WIDTH_BRM'(i);
        end
    end

    assign w_tail_n  = w_kill_ok ? w_kill_tail : (o_ack ? o_alloc_tag : r_tail);
    assign w_head_n  = w_free_ok ? r_head + WIDTH_BRM'(1) : r_head;
    assign w_cnt_up  = {1'b0, r_count} + {{WIDTH_BRM{1'b0}}, o_ack};
    assign w_cnt_dn  = (w_kill_ok ? w_kill_pop : '0) + {{WIDTH_BRM{1'b0}}, w_free_ok};
    assign w_count_n = (w_cnt_dn > w_cnt_up) ? '0 : WIDTH_BRM'(w_cnt_up - w_cnt_dn);
    assign w_err_n   = r_err | (i_free & (r_count == '0)) | (w_kill & w_kill_bad);

    always_comb begin
        w_live_n = r_live;
        if (w_kill_ok)
            w_live_n = w_live_n & ~i_brkill;
        if (o_ack)
            w_live_n[o_alloc_tag] = 1'b1;
        if (w_free_ok)
            w_live_n[r_head] = 1'b0;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tail  <= '0;
            r_head  <= WIDTH_BRM'(1);
            r_count <= '0;
            r_live  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_tail  <= w_tail_n;
            r_head  <= w_head_n;
            r_count <= w_count_n;
            r_live  <= w_live_n;
            r_err   <= w_err_n;
        end
    end
endmodule

// File: tb/tb_branch_tag_ctrl.sv
// tb_branch_tag_ctrl: directed and random checks of branch_tag_ctrl against a queue-of-live-tags model.
module tb_branch_tag_ctrl;
    localparam int W = 4;
    localparam int N = 16;

    logic         clk = 1'b0;
    logic         i_rst_n = 1'b0;
    logic         i_alloc = 1'b0;
    logic         i_free = 1'b0;
    logic [N-1:0] i_brkill = '0;
    logic         o_ready, o_ack, o_err;
    logic [W-1:0] o_alloc_tag, o_brmask, o_count;
    logic [N-1:0] o_live;

    int checks = 0;
    int errors = 0;

    // Model: live tags kept oldest-first in a queue.
    int q[$];
    int m_tail, m_head;
    bit m_err;
    logic         got_ack;
    logic [W-1:0] got_tag;

    branch_tag_ctrl #(.WIDTH_BRM(W)) dut (
        .i_clk(clk), .i_rst_n(i_rst_n), .i_alloc(i_alloc), .i_free(i_free),
        .i_brkill(i_brkill), .o_ready(o_ready), .o_ack(o_ack),
        .o_alloc_tag(o_alloc_tag), .o_brmask(o_brmask), .o_live(o_live),
        .o_count(o_count), .o_err(o_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_live();
        logic [31:0] v = '0;
        foreach (q[i]) v[q[i]] = 1'b1;
        return v;
    endfunction

    task automatic chk_state();
        chk("brmask", 32'(o_brmask), 32'(m_tail));
        chk("count", 32'(o_count), 32'(q.size()));
        chk("live", 32'(o_live), m_live());
        chk("err", 32'(o_err), 32'(m_err));
    endtask

    task automatic model_update(input bit a, input bit f, input logic [N-1:0] k, input bit ack);
        bit bad;
        int nq[$];
        int first_killed;
        bad = (k == '1) || (f && k[m_head]);
        if (f && q.size() == 0) m_err = 1;
        if (k != 0 && bad) m_err = 1;
        if (k != 0 && !bad) begin
            first_killed = -1;
            foreach (q[i]) begin
                if (k[q[i]]) begin
                    if (first_killed < 0) first_killed = q[i];
                end else nq.push_back(q[i]);
            end
            if (first_killed >= 0) m_tail = (first_killed + N - 1) % N;
            q = nq;
        end
        if (ack) begin
            m_tail = (m_tail + 1) % N;
            q.push_back(m_tail);
        end
        if (f && q.size() > 0 && !(k != 0 && !bad && nq.size() == 0 && q.size() == 0)) begin
            void'(q.pop_front());
            m_head = (m_head + 1) % N;
        end
    endtask

    task automatic step(input bit a, input bit f, input logic [N-1:0] k);
        bit e_ready, e_ack;
        i_alloc = a; i_free = f; i_brkill = k;
        e_ready = (q.size() != N - 1);
        e_ack = a && e_ready && (k == 0);
        #3;
        chk("ready", 32'(o_ready), 32'(e_ready));
        chk("ack", 32'(o_ack), 32'(e_ack));
        chk("alloc_tag", 32'(o_alloc_tag), 32'((m_tail + 1) % N));
        got_ack = o_ack;
        got_tag = o_alloc_tag;
        @(posedge clk); #1;
        model_update(a, f, k, e_ack);
        i_alloc = 0; i_free = 0; i_brkill = '0;
        chk_state();
    endtask

    task automatic do_reset();
        i_rst_n = 0; i_alloc = 0; i_free = 0; i_brkill = '0;
        #2;
        q.delete(); m_tail = 0; m_head = 1; m_err = 0;
        chk("rst_ready", 32'(o_ready), 32'd1);
        chk("rst_alloc_tag", 32'(o_alloc_tag), 32'd1);
        chk_state();
        @(posedge clk); #1;
        i_rst_n = 1;
    endtask

    initial begin
        bit a, f;
        int j;
        logic [N-1:0] k;
        #1;
        do_reset();
        // Three allocations grant 1,2,3
        for (int i = 1; i <= 3; i++) begin
            step(1, 0, '0);
            chk("r33_ack", 32'(got_ack), 32'd1);
            chk("r33_tag", 32'(got_tag), 32'(i));
        end
        chk("r33_brmask", 32'(o_brmask), 32'd3);
        chk("r33_live", 32'(o_live), 32'h000E);
        // Kill 2,3 with a competing alloc
        step(1, 0, 16'h000C);
        chk("r34_ack", 32'(got_ack), 32'd0);
        chk("r34_brmask", 32'(o_brmask), 32'd1);
        chk("r34_count", 32'(o_count), 32'd1);
        chk("r34_live", 32'(o_live), 32'h0002);
        // Fill to capacity
        do_reset();
        for (int i = 0; i < 15; i++) step(1, 0, '0);
        chk("r35_full_ready", 32'(o_ready), 32'd0);
        step(1, 0, '0);
        chk("r35_full_ack", 32'(got_ack), 32'd0);
        chk("r35_full_count", 32'(o_count), 32'd15);
        step(0, 1, '0);
        step(1, 1, '0);
        chk("r35_swap_ack", 32'(got_ack), 32'd1);
        chk("r35_swap_count", 32'(o_count), 32'd14);
        step(1, 0, '0);
        chk("r35_refill_count", 32'(o_count), 32'd15);
        // Wrap around tag 15 -> 0
        do_reset();
        for (int i = 0; i < 14; i++) step(1, 0, '0);
        for (int i = 0; i < 9; i++) step(0, 1, '0);
        chk("r36_pre_count", 32'(o_count), 32'd5);
        step(1, 0, '0); chk("r36_tag15", 32'(got_tag), 32'd15);
        step(1, 0, '0); chk("r36_tag0", 32'(got_tag), 32'd0);
        step(1, 0, '0); chk("r36_tag1", 32'(got_tag), 32'd1);
        chk("r36_brmask", 32'(o_brmask), 32'd1);
        step(0, 0, 16'h8003);
        chk("r36_kill_brmask", 32'(o_brmask), 32'd14);
        chk("r36_kill_count", 32'(o_count), 32'd5);
        // Free on empty sets a sticky error
        do_reset();
        step(0, 1, '0);
        chk("r37_err", 32'(o_err), 32'd1);
        step(1, 0, '0); step(0, 0, '0);
        chk("r37_err_hold", 32'(o_err), 32'd1);
        do_reset();
        chk("r37_err_clr", 32'(o_err), 32'd0);
        // Kill and free together
        for (int i = 0; i < 5; i++) step(1, 0, '0);
        step(0, 1, '0);
        step(0, 1, 16'h0030);
        chk("r38_brmask", 32'(o_brmask), 32'd3);
        chk("r38_count", 32'(o_count), 32'd1);
        chk("r38_live", 32'(o_live), 32'h0008);
        // Kill covering head with free flags error
        step(0, 1, 16'h0008);
        chk("r26_err", 32'(o_err), 32'd1);
        // Random legal traffic
        do_reset();
        for (int n = 0; n < 600; n++) begin
            a = ($urandom_range(0, 99) < 60);
            f = (q.size() > 0) && ($urandom_range(0, 99) < 35);
            k = '0;
            if (q.size() > 0 && $urandom_range(0, 9) == 0) begin
                j = $urandom_range(0, q.size() - 1);
                if (f && j == 0) f = 0;
                for (int i = j; i < q.size(); i++) k[q[i]] = 1'b1;
            end
            step(a, f, k);
        end
        // Mid-operation reset: first grant afterwards is tag 1
        do_reset();
        step(1, 0, '0);
        chk("r31_tag", 32'(got_tag), 32'd1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
